spike_event_encoder: RTL and testbench

//  Downstream of the neuron array. Collects the per-column output spike pulses of all

---
 rtl/spike_event_encoder.sv | 139 +++++++++++++
 tb/tb_spike_event_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Spike-to-address-event encoder: time-stamps per-column spike pulses, arbitrates them
// lowest-column-first into an event FIFO, and drains it over a valid/ready handshake.
module spike_event_encoder #(
  parameter int unsigned  NUM_COLS   = 32,
  parameter int unsigned  TS_WIDTH   = 16,
  parameter int unsigned  FIFO_DEPTH = 16,
  localparam int unsigned AW         = $clog2(NUM_COLS),
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_COLS-1:0] spike_in,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [AW-1:0]       event_addr,
  output logic [TS_WIDTH-1:0] event_time,
  output logic [LW-1:0]       fifo_level,
  output logic [15:0]         drop_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = AW + TS_WIDTH;

  logic [TS_WIDTH-1:0] timer_q, timer_d;
  logic [NUM_COLS-1:0] pending_q, pending_d;
  logic [TS_WIDTH-1:0] ts_q [NUM_COLS];
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                valid_q, valid_d;
  logic [DW-1:0]       head_q, head_d;
  logic [15:0]         drop_q, drop_d;

  logic                fifo_empty, fifo_full, pop, can_push, push;
  logic                gnt_found;
  logic [AW-1:0]       gnt_idx;
  logic [NUM_COLS-1:0] gnt_mask, spk, accept, dropped;
  logic [AW:0]         n_drop;
  logic [16:0]         drop_sum;
  logic [DW-1:0]       push_data;
  logic [PW-1:0]       rd_idx;

  // FIFO status from wrap-bit pointers
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    pop        = valid_q && event_ready;
    can_push   = !fifo_full || pop;
  end

  // Lowest-index pending column wins the single push slot
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (pending_q[i] && !gnt_found) begin
        gnt_found = 1'b1;
        gnt_idx   = AW'(i);
      end
    end
    push      = gnt_found && can_push;
    gnt_mask  = push ? (NUM_COLS'(1) << gnt_idx) : '0;
    push_data = {gnt_idx, ts_q[gnt_idx]};
  end

  // A column being granted this cycle can accept a fresh spike; otherwise a busy column drops it
  always_comb begin
    spk       = enable ? spike_in : '0;
    accept    = spk & (~pending_q | gnt_mask);
    dropped   = spk & pending_q & ~gnt_mask;
    pending_d = (pending_q & ~gnt_mask) | accept;
    n_drop    = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      n_drop = n_drop + (AW+1)'(dropped[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    timer_d  = enable ? timer_q + TS_WIDTH'(1) : timer_q;
  end

  // Next pointers and a registered copy of the next head entry
  always_comb begin
    wptr_d  = wptr_q + (PW+1)'(push);
    rptr_d  = rptr_q + (PW+1)'(pop);
    level_d = LW'(wptr_d - rptr_d);
    valid_d = (wptr_d != rptr_d);
    rd_idx  = rptr_d[PW-1:0];
    head_d  = head_q;
    if (valid_d) begin
      if (push && (wptr_q[PW-1:0] == rd_idx)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= '0;
      pending_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      drop_q    <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: pending bits and pointers qualify every read
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (accept[i]) begin
        ts_q[i] <= timer_q;
      end
    end
    if (push) begin
      mem_q[wptr_q[PW-1:0]] <= push_data;
    end
  end

  assign event_valid = valid_q;
  assign event_addr  = head_q[DW-1:TS_WIDTH];
  assign event_time  = head_q[TS_WIDTH-1:0];
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Randomized and directed bench for spike_event_encoder against a queue-based event model.
module tb_spike_event_encoder;

  localparam int NC = 32;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset, enable, event_ready;
  logic [31:0] spike_in;
  logic        event_valid;
  logic [4:0]  event_addr;
  logic [15:0] event_time;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;

  spike_event_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_addr (event_addr),
    .event_time (event_time),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: timer, per-column pending flag + stamp, FIFO of encoded events
  int m_timer;
  bit m_pend [NC];
  int m_ts   [NC];
  int m_q    [$];
  int m_drop;
  int got    [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0;
    m_drop  = 0;
    m_q.delete();
    for (int c = 0; c < NC; c++) begin
      m_pend[c] = 0;
      m_ts[c]   = 0;
    end
  endtask

  task automatic cycle(input logic [31:0] spk, input bit rdy, input bit en, input bit rst);
    bit pop;
    bit old_pend [NC];
    int g;
    int gts;
    spike_in    = spk;
    event_ready = rdy;
    enable      = en;
    reset       = rst;
    if (event_valid && rdy && !rst) got.push_back(int'(event_addr) * 65536 + int'(event_time));
    if (rst) begin
      model_reset();
    end else begin
      pop = (m_q.size() > 0) && rdy;
      g   = -1;
      gts = 0;
      if (m_q.size() < FD || pop) begin
        for (int c = 0; c < NC; c++) if (m_pend[c] && g < 0) g = c;
      end
      if (g >= 0) gts = m_ts[g];
      for (int c = 0; c < NC; c++) old_pend[c] = m_pend[c];
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g * 65536 + gts);
        m_pend[g] = 0;
      end
      if (en) begin
        for (int c = 0; c < NC; c++) begin
          if (spk[c]) begin
            if (!old_pend[c] || c == g) begin
              m_pend[c] = 1;
              m_ts[c]   = m_timer;
            end else if (m_drop < 65535) begin
              m_drop++;
            end
          end
        end
        m_timer = (m_timer + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
    check_eq("valid", 64'(event_valid), 64'(m_q.size() > 0));
    check_eq("level", 64'(fifo_level), 64'(m_q.size()));
    check_eq("drops", 64'(drop_count), 64'(m_drop));
    if (m_q.size() > 0) check_eq("head", 64'({event_addr, event_time}), 64'(m_q[0]));
  endtask

  initial begin
    int gstart;
    int tsrec [20];
    int t1;
    int n2;
    int tf;
    logic [31:0] rs;
    bit rr;

    spike_in = '0; event_ready = 0; enable = 0; reset = 1;
    model_reset();
    cycle('0, 0, 0, 1);
    cycle('0, 0, 0, 1);
    check_eq("rst_addr", 64'(event_addr), 64'd0);
    check_eq("rst_time", 64'(event_time), 64'd0);
    check_eq("rst_valid", 64'(event_valid), 64'd0);

    // 1: single spike at timer 10
    while (m_timer != 10) cycle('0, 1, 1, 0);
    cycle(32'h1 << 5, 1, 1, 0);
    check_eq("t1_nolat", 64'(event_valid), 64'd0);
    cycle('0, 1, 1, 0);
    check_eq("t1_valid", 64'(event_valid), 64'd1);
    check_eq("t1_addr", 64'(event_addr), 64'd5);
    check_eq("t1_time", 64'(event_time), 64'd10);
    check_eq("t1_drop", 64'(drop_count), 64'd0);

    // 2: simultaneous spikes emerge in ascending column order
    cycle('0, 1, 1, 1);
    while (m_timer != 3) cycle('0, 1, 1, 0);
    cycle(32'h0000_0109, 1, 1, 0);
    cycle('0, 1, 1, 0);
    check_eq("t2_a0", 64'({event_addr, event_time}), {43'd0, 5'd0, 16'd3});
    cycle('0, 1, 1, 0);
    check_eq("t2_a3", 64'({event_addr, event_time}), {43'd0, 5'd3, 16'd3});
    cycle('0, 1, 1, 0);
    check_eq("t2_a8", 64'({event_addr, event_time}), {43'd0, 5'd8, 16'd3});

    // 3: backpressure fills the FIFO, then all 20 drain in order
    cycle('0, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      tsrec[i] = m_timer;
      cycle(32'h1 << i, 0, 1, 0);
    end
    cycle('0, 0, 1, 0);
    cycle('0, 0, 1, 0);
    check_eq("t3_full", 64'(fifo_level), 64'd16);
    gstart = got.size();
    for (int k = 0; k < 100 && got.size() - gstart < 20; k++) cycle('0, 1, 1, 0);
    check_eq("t3_count", 64'(got.size() - gstart), 64'd20);
    if (got.size() - gstart >= 20)
      for (int i = 0; i < 20; i++) check_eq("t3_order", 64'(got[gstart + i]), 64'(i * 65536 + tsrec[i]));
    check_eq("t3_drop", 64'(drop_count), 64'd0);

    // 4: re-fire while pending behind a full FIFO drops the second spike
    cycle('0, 1, 1, 1);
    for (int i = 0; i < 16; i++) cycle(32'h1 << (10 + i), 0, 1, 0);
    cycle('0, 0, 1, 0);
    check_eq("t4_full", 64'(fifo_level), 64'd16);
    t1 = m_timer;
    cycle(32'h4, 0, 1, 0);
    cycle(32'h4, 0, 1, 0);
    cycle('0, 0, 1, 0);
    check_eq("t4_drop", 64'(drop_count), 64'd1);
    gstart = got.size();
    for (int k = 0; k < 100 && got.size() - gstart < 17; k++) cycle('0, 1, 1, 0);
    check_eq("t4_count", 64'(got.size() - gstart), 64'd17);
    n2 = 0;
    for (int i = gstart; i < got.size(); i++) begin
      if (got[i] / 65536 == 2) begin
        n2++;
        check_eq("t4_time", 64'(got[i] % 65536), 64'(t1));
      end
    end
    check_eq("t4_n2", 64'(n2), 64'd1);

    // 6: reset mid-operation discards FIFO and pending events
    cycle('0, 1, 1, 1);
    cycle(32'h0000_03FF, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle('0, 0, 1, 0);
    check_eq("t6_lvl7", 64'(fifo_level), 64'd7);
    cycle('0, 0, 1, 1);
    check_eq("t6_valid", 64'(event_valid), 64'd0);
    check_eq("t6_level", 64'(fifo_level), 64'd0);
    gstart = got.size();
    for (int i = 0; i < 20; i++) cycle('0, 1, 1, 0);
    check_eq("t6_stale", 64'(got.size() - gstart), 64'd0);

    // enable=0: spikes ignored, timer frozen
    tf = m_timer;
    for (int i = 0; i < 10; i++) cycle($urandom, 1, 0, 0);
    check_eq("en0_level", 64'(fifo_level), 64'd0);
    check_eq("en0_drop", 64'(drop_count), 64'd0);
    cycle(32'h10, 1, 1, 0);
    cycle('0, 1, 1, 0);
    check_eq("en0_time", 64'(event_time), 64'(tf));
    check_eq("en0_addr", 64'(event_addr), 64'd4);

    // Random traffic: alternating light and heavy backpressure phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        rs = $urandom & $urandom & $urandom;
        if ($urandom_range(0, 3) == 0) rs = '0;
        rr = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        cycle(rs, rr, $urandom_range(0, 15) != 0, 0);
      end
    end
    for (int k = 0; k < 200 && m_q.size() > 0; k++) cycle('0, 1, 1, 0);

    // 5: timestamp wrap
    while (m_timer != 16'hFFFF) cycle('0, 1, 1, 0);
    for (int k = 0; k < 100 && m_q.size() > 0; k++) cycle('0, 1, 1, 0);
    while (m_timer != 16'hFFFF) cycle('0, 1, 1, 0);
    gstart = got.size();
    cycle(32'h80, 1, 1, 0);
    cycle(32'h200, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle('0, 1, 1, 0);
    check_eq("t5_count", 64'(got.size() - gstart), 64'd2);
    if (got.size() - gstart >= 2) begin
      check_eq("t5_ffff", 64'(got[gstart]), 64'(7 * 65536 + 65535));
      check_eq("t5_zero", 64'(got[gstart + 1]), 64'(9 * 65536));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
